regfile_scrubber: RTL

//   Background parity scrubber for the parity-protected 16x32 register file. Steals idle read-port cycles,

---
 rtl/regfile_scrubber.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/regfile_scrubber.sv
// regfile_scrubber: background even-parity scrubber for the parity-protected register file.
// It uses idle read-port cycles to walk every register and check data against the stored parity.
// It logs the first failing address, keeps a saturating error count and pulses an interrupt.
// Optional macro SCRUB_FIX_EN adds a FIX state that writes 0 back into each failing entry.
module regfile_scrubber #(
  parameter int unsigned NUM_REGS  = 16,
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned INTERVAL  = 256,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 core_idle,
  output logic [ADDR_W-1:0]    scrub_addr,
  input  logic [DATA_W-1:0]    scrub_data,
  input  logic                 scrub_par,
  output logic                 busy,
  output logic                 pass_done,
  output logic                 err_irq,
  output logic                 err_valid,
  output logic [ADDR_W-1:0]    err_addr,
  output logic [ERR_CNT_W-1:0] err_count,
  input  logic                 err_clr,
  output logic                 wr_req,
  output logic [ADDR_W-1:0]    wr_addr,
  output logic [DATA_W-1:0]    wr_data,
  input  logic                 wr_gnt
);

  localparam int unsigned           CNT_W      = $clog2(INTERVAL + 1);
  localparam logic [CNT_W-1:0]      CNT_RELOAD = CNT_W'(INTERVAL);
  localparam logic [ADDR_W-1:0]     LAST_ADDR  = ADDR_W'(NUM_REGS - 1);
  localparam logic [ERR_CNT_W-1:0]  ERR_ONE    = ERR_CNT_W'(1);

  typedef enum logic [2:0] {StWait, StRead, StCheck, StFix, StDone} state_e;

  state_e           state;
  logic [CNT_W-1:0] wait_cnt;
  logic             mismatch;
  logic             advance;

  // err_irq is loaded at capture time with the parity result, so during CHECK it is the
  // mismatch flag for the register being checked.
  assign mismatch = (state == StCheck) && err_irq;

`ifdef SCRUB_FIX_EN
  // Finish a register on a clean check, or once the repair write has been granted.
  assign advance = ((state == StCheck) && !mismatch) || ((state == StFix) && wr_gnt);
  assign wr_data = '0;

  // Repair request: raised on leaving CHECK with a mismatch, held until wr_gnt is sampled.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_req  <= 1'b0;
      wr_addr <= '0;
    end else if (mismatch) begin
      wr_req  <= 1'b1;
      wr_addr <= scrub_addr;
    end else if ((state == StFix) && wr_gnt) begin
      wr_req  <= 1'b0;
    end
  end
`else
  // Detection only: every CHECK finishes its register.
  assign advance = (state == StCheck);
  assign wr_req  = 1'b0;
  assign wr_addr = '0;
  assign wr_data = '0;

  logic unused_wr_gnt;
  assign unused_wr_gnt = wr_gnt;
`endif

  // Main scan FSM with registered busy/pass_done/err_irq/scrub_addr.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= StWait;
      wait_cnt   <= CNT_RELOAD;
      scrub_addr <= '0;
      busy       <= 1'b0;
      pass_done  <= 1'b0;
      err_irq    <= 1'b0;
    end else begin
      pass_done <= 1'b0;
      err_irq   <= 1'b0;
      if (advance) begin
        if (!enable) begin
          // Pass aborted: back to WAIT without a pass_done pulse.
          state      <= StWait;
          busy       <= 1'b0;
          scrub_addr <= '0;
          wait_cnt   <= CNT_RELOAD;
        end else if (scrub_addr == LAST_ADDR) begin
          state      <= StDone;
          pass_done  <= 1'b1;
          scrub_addr <= '0;
          wait_cnt   <= CNT_RELOAD;
        end else begin
          state      <= StRead;
          scrub_addr <= scrub_addr + ADDR_W'(1);
        end
      end else begin
        unique case (state)
          StWait: begin
            if (!enable) begin
              wait_cnt <= CNT_RELOAD;
            end else if ((wait_cnt == CNT_W'(1)) || (wait_cnt == '0)) begin
              wait_cnt <= '0;
              state    <= StRead;
              busy     <= 1'b1;
            end else begin
              wait_cnt <= wait_cnt - CNT_W'(1);
            end
          end
          StRead: begin
            if (core_idle) begin
              state   <= StCheck;
              err_irq <= scrub_par ^ (^scrub_data);
            end
          end
          // Only reached with a repair pending; clean checks take the advance path.
          StCheck: state <= StFix;
          // Waiting for the repair write to be granted.
          StFix:   state <= StFix;
          StDone: begin
            state <= StWait;
            busy  <= 1'b0;
          end
          default: begin
            state <= StWait;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Error log: first address sticks; a clear in the same cycle as a new error yields that error.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_valid <= 1'b0;
      err_addr  <= '0;
      err_count <= '0;
    end else if (mismatch) begin
      err_valid <= 1'b1;
      if (err_clr) begin
        err_addr  <= scrub_addr;
        err_count <= ERR_ONE;
      end else begin
        if (!err_valid) begin
          err_addr <= scrub_addr;
        end
        if (err_count != '1) begin
          err_count <= err_count + ERR_ONE;
        end
      end
    end else if (err_clr) begin
      err_valid <= 1'b0;
      err_addr  <= '0;
      err_count <= '0;
    end
  end

endmodule
